// File: rtl/defs_vga.sv
// -----------------------------------------------------------------------------
// defs_vga
// Shared VGA definitions: active-area sizes used for coordinate port widths,
// the 12-bit (4:4:4) colour palette of the Game-of-Life renderer, and the
// per-pixel attribute bundle that travels alongside the cell RAM read.
// -----------------------------------------------------------------------------
package defs_vga;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_V_ACTIVE = 480;

  // Palette, 4 bits each of R:G:B
  localparam logic [11:0] VGA_COLOR_BG    = 12'h112;
  localparam logic [11:0] VGA_COLOR_GRID  = 12'h444;
  localparam logic [11:0] VGA_COLOR_ALIVE = 12'hFF0;
  localparam logic [11:0] VGA_COLOR_DEAD  = 12'h008;

  // Everything about a pixel that is known before the cell state arrives
  typedef struct packed {
    logic h_sync;
    logic v_sync;
    logic active;
    logic in_field;
    logic grid;
  } pix_attr_t;

  // Blanking pixel: syncs released, nothing drawn
  localparam pix_attr_t PIX_ATTR_IDLE = '{h_sync: 1'b1, v_sync: 1'b1,
                                         active: 1'b0, in_field: 1'b0,
                                         grid: 1'b0};

endpackage

// File: rtl/pipe_delay.sv
// -----------------------------------------------------------------------------
// pipe_delay
// Fixed-depth shift register whose stages reset to a parameter value, so a
// delayed bundle of control signals looks "idle" straight out of reset.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   i_data      WIDTH-bit value entering the line
//   o_data      i_data delayed by DEPTH cycles
// -----------------------------------------------------------------------------
module pipe_delay #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= RESET_VAL;
    end else begin
      r_stage[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_renderer.sv
// -----------------------------------------------------------------------------
// vga_renderer
// Pixel stage after the VGA timing generator. Maps each active pixel to a
// Game-of-Life cell, reads that cell from synchronous RAM, and drives 12-bit
// RGB with syncs delayed to match (latency RAM_LATENCY+2). Also counts frames
// and raises a step request to the life engine every FRAMES_PER_STEP frames.
// Ports:
//   clk, rst_n                       pixel clock, async active-low reset
//   i_draw_active, i_active_x/y      active-area flag and coordinates
//   i_h_sync, i_v_sync               active-low syncs in
//   o_rd_en, o_rd_addr, i_rd_data    cell RAM read port (row-major index)
//   o_r, o_g, o_b                    pixel colour
//   o_h_sync, o_v_sync               latency-aligned syncs
//   i_pause                          drop step requests while high
//   o_step_req, i_step_ack           level request / single-cycle accept
//   o_overrun                        sticky: step came due while one pending
// -----------------------------------------------------------------------------
module vga_renderer
  import defs_vga::*;
#(
  parameter int CELL_SIZE       = 8,
  parameter int FIELD_W         = 80,
  parameter int FIELD_H         = 60,
  parameter int RAM_LATENCY     = 1,
  parameter int FRAMES_PER_STEP = 30,
  parameter int GRID_EN         = 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                i_draw_active,
  input  logic [$clog2(VGA_H_ACTIVE)-1:0]     i_active_x,
  input  logic [$clog2(VGA_V_ACTIVE)-1:0]     i_active_y,
  input  logic                                i_h_sync,
  input  logic                                i_v_sync,
  output logic                                o_rd_en,
  output logic [$clog2(FIELD_W*FIELD_H)-1:0]  o_rd_addr,
  input  logic                                i_rd_data,
  output logic [3:0]                          o_r,
  output logic [3:0]                          o_g,
  output logic [3:0]                          o_b,
  output logic                                o_h_sync,
  output logic                                o_v_sync,
  input  logic                                i_pause,
  output logic                                o_step_req,
  input  logic                                i_step_ack,
  output logic                                o_overrun
);

  localparam int XW    = $clog2(VGA_H_ACTIVE);
  localparam int YW    = $clog2(VGA_V_ACTIVE);
  localparam int AW    = $clog2(FIELD_W*FIELD_H);
  localparam int SHIFT = $clog2(CELL_SIZE);
  localparam int CW    = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  localparam logic [31:0]   FIELD_PX_W = 32'(FIELD_W*CELL_SIZE);
  localparam logic [31:0]   FIELD_PX_H = 32'(FIELD_H*CELL_SIZE);
  localparam logic [CW-1:0] CNT_LAST   = CW'(FRAMES_PER_STEP-1);

  logic [XW-1:0] w_cell_x;
  logic [YW-1:0] w_cell_y;
  logic [AW-1:0] w_addr;
  logic          w_in_field;
  logic          w_grid;
  pix_attr_t     w_attr_in;
  pix_attr_t     w_attr_dly;
  logic [11:0]   w_color;

  logic          r_rd_en;
  logic [AW-1:0] r_rd_addr;
  logic [11:0]   r_rgb;
  logic          r_h_sync;
  logic          r_v_sync;

  logic          r_vs_prev;
  logic [CW-1:0] r_frame_cnt;
  logic          w_frame_evt;
  logic          w_step_due;
  logic          r_step_req;
  logic          r_overrun;

  // Cell coordinates are plain shifts because CELL_SIZE is a power of two
  assign w_cell_x   = i_active_x >> SHIFT;
  assign w_cell_y   = i_active_y >> SHIFT;
  assign w_addr     = AW'(w_cell_y) * AW'(FIELD_W) + AW'(w_cell_x);
  assign w_in_field = i_draw_active
                      && (32'(i_active_x) < FIELD_PX_W)
                      && (32'(i_active_y) < FIELD_PX_H);
  // A grid pixel is the first row or column of each cell
  assign w_grid     = (GRID_EN != 0)
                      && ((i_active_x[SHIFT-1:0] == '0)
                          || (i_active_y[SHIFT-1:0] == '0));

  assign w_attr_in = '{h_sync: i_h_sync, v_sync: i_v_sync,
                       active: i_draw_active, in_field: w_in_field,
                       grid: w_grid};

  // RAM read request; the address is held between reads so the RAM port
  // only toggles inside the field
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
    end else begin
      r_rd_en <= w_in_field;
      if (w_in_field) r_rd_addr <= w_addr;
    end
  end

  // Attributes wait out the read register plus the RAM latency, arriving
  // together with i_rd_data; the output register adds the final cycle
  pipe_delay #(
    .WIDTH    ($bits(pix_attr_t)),
    .DEPTH    (RAM_LATENCY + 1),
    .RESET_VAL(PIX_ATTR_IDLE)
  ) u_attr_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .i_data(w_attr_in),
    .o_data(w_attr_dly)
  );

  // Grid overrides cell state; blanking is always black
  always_comb begin
    w_color = 12'h000;
    if (!w_attr_dly.active)        w_color = 12'h000;
    else if (!w_attr_dly.in_field) w_color = VGA_COLOR_BG;
    else if (w_attr_dly.grid)      w_color = VGA_COLOR_GRID;
    else if (i_rd_data)            w_color = VGA_COLOR_ALIVE;
    else                           w_color = VGA_COLOR_DEAD;
  end

  // Output register for colour and the aligned syncs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb    <= 12'h000;
      r_h_sync <= 1'b1;
      r_v_sync <= 1'b1;
    end else begin
      r_rgb    <= w_color;
      r_h_sync <= w_attr_dly.h_sync;
      r_v_sync <= w_attr_dly.v_sync;
    end
  end

  // Frame event on v_sync falling; the counter wrap is the step-due point
  assign w_frame_evt = r_vs_prev && !i_v_sync;
  assign w_step_due  = w_frame_evt && (r_frame_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_prev   <= 1'b1;
      r_frame_cnt <= '0;
    end else begin
      r_vs_prev <= i_v_sync;
      if (w_frame_evt) r_frame_cnt <= w_step_due ? '0 : r_frame_cnt + 1'b1;
    end
  end

  // Step handshake: a due step wins over a same-cycle ack, and only counts
  // as an overrun when the pending request was not being accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step_req <= 1'b0;
      r_overrun  <= 1'b0;
    end else if (w_step_due && !i_pause) begin
      if (r_step_req && !i_step_ack) r_overrun <= 1'b1;
      r_step_req <= 1'b1;
    end else if (r_step_req && i_step_ack) begin
      r_step_req <= 1'b0;
    end
  end

  assign o_rd_en    = r_rd_en;
  assign o_rd_addr  = r_rd_addr;
  assign o_r        = r_rgb[11:8];
  assign o_g        = r_rgb[7:4];
  assign o_b        = r_rgb[3:0];
  assign o_h_sync   = r_h_sync;
  assign o_v_sync   = r_v_sync;
  assign o_step_req = r_step_req;
  assign o_overrun  = r_overrun;

endmodule

// File: tb/tb_vga_renderer.sv
// Directed bench for vga_renderer. Two instances share the inputs:
// dutA = defaults with FRAMES_PER_STEP=2 (latency 3),
// dutB = RAM_LATENCY=3, FIELD_W=40 (latency 5, field ends at x=320).
module tb_vga_renderer;
   import defs_vga::*;

   logic        clock = 1'b0;
   logic        rst_n = 1'b0;
   logic        drawActive = 1'b0;
   logic [9:0]  activeX = '0;
   logic [8:0]  activeY = '0;
   logic        hSync = 1'b1;
   logic        vSync = 1'b1;
   logic        pause = 1'b0;
   logic        stepAck = 1'b0;

   logic        rdEnA, rdEnB, rdDataA, rdDataB;
   logic [12:0] rdAddrA;
   logic [11:0] rdAddrB;
   logic [3:0]  rA, gA, bA, rB, gB, bB;
   logic        hsA, vsA, hsB, vsB;
   logic        stepReqA, stepReqB, overrunA, overrunB;

   int checkCount = 0;
   int errorCount = 0;

   always #5 clock = ~clock;

   vga_renderer #(.FRAMES_PER_STEP(2)) dutA (
      .clk(clock), .rst_n(rst_n), .i_draw_active(drawActive),
      .i_active_x(activeX), .i_active_y(activeY),
      .i_h_sync(hSync), .i_v_sync(vSync),
      .o_rd_en(rdEnA), .o_rd_addr(rdAddrA), .i_rd_data(rdDataA),
      .o_r(rA), .o_g(gA), .o_b(bA), .o_h_sync(hsA), .o_v_sync(vsA),
      .i_pause(pause), .o_step_req(stepReqA), .i_step_ack(stepAck),
      .o_overrun(overrunA));

   vga_renderer #(.RAM_LATENCY(3), .FIELD_W(40)) dutB (
      .clk(clock), .rst_n(rst_n), .i_draw_active(drawActive),
      .i_active_x(activeX), .i_active_y(activeY),
      .i_h_sync(hSync), .i_v_sync(vSync),
      .o_rd_en(rdEnB), .o_rd_addr(rdAddrB), .i_rd_data(rdDataB),
      .o_r(rB), .o_g(gB), .o_b(bB), .o_h_sync(hsB), .o_v_sync(vsB),
      .i_pause(pause), .o_step_req(stepReqB), .i_step_ack(1'b0),
      .o_overrun(overrunB));

   // Cell field model: a cell is alive when its index mod 3 is 1
   function automatic logic cellAlive(input int addr);
      return (addr % 3) == 1;
   endfunction

   // One-cycle RAM for dutA
   logic ramAq = 1'b0;
   always @(posedge clock) if (rdEnA) ramAq <= cellAlive(int'(rdAddrA));
   assign rdDataA = ramAq;

   // Three-cycle RAM for dutB
   logic [2:0] ramBq = '0;
   always @(posedge clock) ramBq <= {ramBq[1:0], rdEnB ? cellAlive(int'(rdAddrB)) : 1'b0};
   assign rdDataB = ramBq[2];

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic waitCycle();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic act, input int x, input int y,
                                input logic hs, input logic vs);
      drawActive = act;
      activeX    = 10'(x);
      activeY    = 9'(y);
      hSync      = hs;
      vSync      = vs;
   endtask

   task automatic applyIdle();
      applyStimulus(1'b0, 0, 0, 1'b1, 1'b1);
   endtask

   task automatic applyReset();
      applyIdle();
      rst_n = 1'b0;
      waitCycle();
      waitCycle();
      rst_n = 1'b1;
      waitCycle();
   endtask

   // Two cycles of v_sync low then two high: exactly one frame event
   task automatic vsyncPulse();
      vSync = 1'b0;
      waitCycle();
      waitCycle();
      vSync = 1'b1;
      waitCycle();
      waitCycle();
   endtask

   // Directed pixel vectors: x, y, active, expected addrA, rdEnB, colour A, colour B
   typedef struct {
      int          x;
      int          y;
      logic        act;
      int          addrA;
      logic        rdEnB;
      logic [11:0] colA;
      logic [11:0] colB;
   } pixVec_t;

   pixVec_t vecs[7];

   // Sync scan history
   logic hsHist[0:79];
   logic vsHist[0:79];
   logic actHist[0:79];

   task automatic syncScan(input string name);
      int n = 60;
      for (int j = 0; j < n + 6; j++) begin
         int ph = j % 12;
         if (j < n) begin
            logic hs  = !(ph >= 9 && ph < 11);
            logic vs  = !(j >= 40 && j < 44);
            logic act = (ph < 8) && vs && (j < 36);
            if (act) applyStimulus(1'b1, ph * 45 + 3, (j / 12) * 7 + 1, hs, vs);
            else     applyStimulus(1'b0, 0, 0, hs, vs);
         end else begin
            applyIdle();
         end
         hsHist[j]  = hSync;
         vsHist[j]  = vSync;
         actHist[j] = drawActive;
         waitCycle();
         if (j >= 2) begin
            checkOutput({name, " syncA"}, {hsA, vsA}, {hsHist[j-2], vsHist[j-2]});
            if (!actHist[j-2]) checkOutput({name, " blankA"}, {rA, gA, bA}, 12'h000);
         end
         if (j >= 4) begin
            checkOutput({name, " syncB"}, {hsB, vsB}, {hsHist[j-4], vsHist[j-4]});
            if (!actHist[j-4]) checkOutput({name, " blankB"}, {rB, gB, bB}, 12'h000);
         end
      end
   endtask

   initial begin
      vecs[0] = '{17,  9,   1'b1, 82,   1'b1, VGA_COLOR_ALIVE, VGA_COLOR_DEAD};
      vecs[1] = '{16,  9,   1'b1, 82,   1'b1, VGA_COLOR_GRID,  VGA_COLOR_GRID};
      vecs[2] = '{20,  8,   1'b1, 82,   1'b1, VGA_COLOR_GRID,  VGA_COLOR_GRID};
      vecs[3] = '{25,  10,  1'b1, 83,   1'b1, VGA_COLOR_DEAD,  VGA_COLOR_ALIVE};
      vecs[4] = '{330, 10,  1'b1, 121,  1'b0, VGA_COLOR_ALIVE, VGA_COLOR_BG};
      vecs[5] = '{639, 479, 1'b1, 4799, 1'b0, VGA_COLOR_DEAD,  VGA_COLOR_BG};
      vecs[6] = '{0,   0,   1'b0, 4799, 1'b0, 12'h000,         12'h000};

      // Reset state while rst_n is still low
      #12;
      checkOutput("reset rgbA",    {rA, gA, bA}, 12'h000);
      checkOutput("reset syncA",   {hsA, vsA}, 2'b11);
      checkOutput("reset rdEnA",   rdEnA, 1'b0);
      checkOutput("reset rdAddrA", rdAddrA, 13'd0);
      checkOutput("reset stepA",   {stepReqA, overrunA}, 2'b00);
      rst_n = 1'b1;
      waitCycle();

      // Directed pixels, one at a time
      foreach (vecs[v]) begin
         applyStimulus(vecs[v].act, vecs[v].x, vecs[v].y, 1'b1, 1'b1);
         waitCycle();
         applyIdle();
         checkOutput($sformatf("pix%0d rdEnA", v), rdEnA, vecs[v].act);
         checkOutput($sformatf("pix%0d rdAddrA", v), rdAddrA, vecs[v].addrA);
         checkOutput($sformatf("pix%0d rdEnB", v), rdEnB, vecs[v].rdEnB);
         waitCycle();
         waitCycle();
         checkOutput($sformatf("pix%0d colourA", v), {rA, gA, bA}, vecs[v].colA);
         waitCycle();
         waitCycle();
         checkOutput($sformatf("pix%0d colourB", v), {rB, gB, bB}, vecs[v].colB);
         waitCycle();
      end

      syncScan("scan1");

      // Asynchronous reset in the middle of a line with live outputs
      applyStimulus(1'b1, 17, 9, 1'b0, 1'b1);
      waitCycle();
      waitCycle();
      waitCycle();
      checkOutput("preRst colourA", {rA, gA, bA}, VGA_COLOR_ALIVE);
      checkOutput("preRst hsA", hsA, 1'b0);
      rst_n = 1'b0;
      #2;
      checkOutput("midRst colourA", {rA, gA, bA}, 12'h000);
      checkOutput("midRst hsA", hsA, 1'b1);
      checkOutput("midRst rdEnA", rdEnA, 1'b0);
      checkOutput("midRst rdAddrA", rdAddrA, 13'd0);
      applyReset();

      // Step pacing, FRAMES_PER_STEP=2
      vsyncPulse();
      checkOutput("frame1 req", stepReqA, 1'b0);
      vsyncPulse();
      checkOutput("frame2 req", stepReqA, 1'b1);
      waitCycle();
      waitCycle();
      waitCycle();
      stepAck = 1'b1;
      waitCycle();
      stepAck = 1'b0;
      checkOutput("ack clears req", stepReqA, 1'b0);
      checkOutput("ack overrun", overrunA, 1'b0);
      vsyncPulse();
      vsyncPulse();
      checkOutput("frame4 req", stepReqA, 1'b1);
      checkOutput("frame4 overrun", overrunA, 1'b0);
      vsyncPulse();
      vsyncPulse();
      checkOutput("frame6 overrun", overrunA, 1'b1);
      checkOutput("frame6 req", stepReqA, 1'b1);

      // Ack coinciding with a due step
      applyReset();
      checkOutput("rst clears overrun", overrunA, 1'b0);
      vsyncPulse();
      vsyncPulse();
      vsyncPulse();
      vSync   = 1'b0;
      stepAck = 1'b1;
      waitCycle();
      stepAck = 1'b0;
      checkOutput("ackDue req", stepReqA, 1'b1);
      checkOutput("ackDue overrun", overrunA, 1'b0);
      waitCycle();
      vSync = 1'b1;
      waitCycle();
      waitCycle();
      stepAck = 1'b1;
      waitCycle();
      stepAck = 1'b0;
      checkOutput("ack2 clears req", stepReqA, 1'b0);

      // Pause drops due steps
      pause = 1'b1;
      vsyncPulse();
      vsyncPulse();
      checkOutput("pause req", stepReqA, 1'b0);
      pause = 1'b0;
      checkOutput("pause overrun", overrunA, 1'b0);

      // Clean frame after the resets
      syncScan("scan2");

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
